ifetch_queue: RTL and testbench

//  Fetch stage of the pipelined RV32I core. Holds the fetch PC and issues single-outstanding reads to the I-cache.

---
 rtl/ifetch_queue_pkg.sv | 37 +++
 rtl/ifq_fifo.sv | 51 +++++
 rtl/ifetch_queue.sv | 145 ++++++++++++++
 tb/tb_ifetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: RV32I fetch-stage types shared by ifetch_queue and ifq_fifo.
// Word, opcode, FIFO entry and fetch FSM state definitions.
package ifetch_queue_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } ifq_state_t;

  localparam rv32i_word IFQ_RESET_PC = 32'h0000_0060;

  function automatic rv32i_word word_align(rv32i_word a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: small {pc, instr} FIFO for the fetch stage.
// clear has priority over push and pop in the same cycle.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  ifq_entry_t             din,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output ifq_entry_t             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push && !clear && !rst) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: RV32I fetch stage, single-outstanding I-cache reads into a FIFO.
// Optional IFQ_PERF_EN adds fetch/flush/stall performance counters.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter rv32i_word RESET_PC = IFQ_RESET_PC,
  parameter int        DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        dec_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t    state;
  ifq_state_t    state_n;
  rv32i_word     fetch_pc;
  rv32i_word     fetch_pc_n;
  rv32i_word     req_addr;
  rv32i_word     req_addr_n;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  ifq_entry_t    din;
  ifq_entry_t    head;
  logic          push;
  logic          pop;
  logic          space;

  assign pop  = if_valid && dec_ready;
  assign push = (state == BUSY) && inst_resp && !redirect_valid;

  // occupancy after this cycle's push/pop; a request is only issued into a free slot
  assign occ   = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign space = occ < (CW+1)'(DEPTH);

  assign din = '{pc: req_addr, instr: inst_rdata};

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    unique case (state)
      IDLE: begin
        if (space && !redirect_valid) begin
          req_addr_n = fetch_pc;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (inst_resp) begin
          if (!redirect_valid) begin
            fetch_pc_n = fetch_pc + 32'd4;
            if (space) begin
              req_addr_n = fetch_pc + 32'd4;
            end else begin
              state_n = IDLE;
            end
          end else begin
            state_n = IDLE;
          end
        end else if (redirect_valid) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (inst_resp) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_n = word_align(redirect_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
    end
  end

  assign inst_read = (state != IDLE);
  assign inst_addr = req_addr;

  assign if_valid  = (count != '0);
  assign if_pc     = if_valid ? head.pc : '0;
  assign if_instr  = if_valid ? head.instr : '0;
  assign if_opcode = if_instr[6:0];
  assign if_funct3 = if_instr[14:12];
  assign if_funct7 = if_instr[31:25];

`ifdef IFQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(push);
      perf_flush_cnt <= perf_flush_cnt + 32'(redirect_valid);
      perf_stall_cnt <= perf_stall_cnt + 32'(if_valid && !dec_ready);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed checks of ifetch_queue with a latency-programmable I-cache model.
// Define IFQ_PERF_EN to also exercise the performance counters.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [2:0]  if_funct3;
  logic [6:0]  if_funct7;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 0;
  int wcnt   = 0;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .inst_read      (inst_read),
    .inst_addr      (inst_addr),
    .inst_resp      (inst_resp),
    .inst_rdata     (inst_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .dec_ready      (dec_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_funct3      (if_funct3),
    .if_funct7      (if_funct7)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h5a3c_1013;
  endfunction

  // I-cache: responds after lat idle cycles of a held request
  always @(negedge clk) begin
    if (!inst_read) begin
      inst_resp = 1'b0;
      wcnt      = 0;
    end else if (wcnt >= lat) begin
      inst_resp  = 1'b1;
      inst_rdata = mem_word(inst_addr);
      wcnt       = 0;
    end else begin
      inst_resp = 1'b0;
      wcnt      = wcnt + 1;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(int l, logic dr);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = dr;
    lat            = l;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] w;
  logic        seen;

  initial begin
    // 1: reset state, then back-to-back fetch with a zero-wait cache
    do_reset(0, 1'b1);
    chk("rst_read", 32'(inst_read), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    tick();
    chk("t1_addr0", inst_addr, 32'h60);
    chk("t1_read", 32'(inst_read), 32'd1);
    chk("t1_nvalid", 32'(if_valid), 32'd0);
    tick();
    w = mem_word(32'h60);
    chk("t1_addr1", inst_addr, 32'h64);
    chk("t1_pc0", if_pc, 32'h60);
    chk("t1_ins0", if_instr, w);
    chk("t1_opc", 32'(if_opcode), 32'(w[6:0]));
    chk("t1_f3", 32'(if_funct3), 32'(w[14:12]));
    chk("t1_f7", 32'(if_funct7), 32'(w[31:25]));
    tick();
    chk("t1_addr2", inst_addr, 32'h68);
    chk("t1_pc1", if_pc, 32'h64);

    // 2: decode stalled, FIFO fills to DEPTH and fetch stops
    do_reset(0, 1'b0);
    repeat (5) tick();
    chk("t2_full_read", 32'(inst_read), 32'd0);
    chk("t2_head", if_pc, 32'h60);
    tick();
    chk("t2_hold_read", 32'(inst_read), 32'd0);
    chk("t2_hold_head", if_pc, 32'h60);
    dec_ready = 1'b1;
    tick();
    chk("t2_pop_pc", if_pc, 32'h64);
    chk("t2_resume_rd", 32'(inst_read), 32'd1);
    chk("t2_resume_ad", inst_addr, 32'h70);

    // 3: redirect while a slow request is outstanding
    do_reset(3, 1'b1);
    repeat (5) tick();
    chk("t3_busy_addr", inst_addr, 32'h64);
    chk("t3_head", if_pc, 32'h60);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t3_drop_addr", inst_addr, 32'h64);
    chk("t3_drop_read", 32'(inst_read), 32'd1);
    chk("t3_flushed", 32'(if_valid), 32'd0);
    tick();
    chk("t3_drop_addr2", inst_addr, 32'h64);
    tick();
    tick();
    chk("t3_idle_read", 32'(inst_read), 32'd0);
    chk("t3_discard", 32'(if_valid), 32'd0);
    tick();
    chk("t3_new_addr", inst_addr, 32'h200);
    chk("t3_new_read", 32'(inst_read), 32'd1);
    for (int i = 0; i < 8 && !if_valid; i++) tick();
    chk("t3_fill", 32'(if_valid), 32'd1);
    chk("t3_fill_pc", if_pc, 32'h200);
    chk("t3_fill_ins", if_instr, mem_word(32'h200));

    // 4: redirect collides with response and pop
    do_reset(0, 1'b1);
    tick();
    tick();
    chk("t4_head", if_pc, 32'h60);
    chk("t4_addr", inst_addr, 32'h64);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h303;
    tick();
    redirect_valid = 1'b0;
    seen = (if_valid && if_pc == 32'h64);
    chk("t4_empty", 32'(if_valid), 32'd0);
    chk("t4_idle", 32'(inst_read), 32'd0);
    tick();
    seen = seen || (if_valid && if_pc == 32'h64);
    chk("t4_fetch_ad", inst_addr, 32'h300);
    chk("t4_still_mt", 32'(if_valid), 32'd0);
    tick();
    seen = seen || (if_valid && if_pc == 32'h64);
    chk("t4_pc", if_pc, 32'h300);
    chk("t4_valid", 32'(if_valid), 32'd1);
    chk("t4_next_ad", inst_addr, 32'h304);
    chk("t4_no_64", 32'(seen), 32'd0);

    // 5: reset while busy with entries queued
    do_reset(0, 1'b0);
    repeat (3) tick();
    chk("t5_queued", 32'(if_valid), 32'd1);
    chk("t5_busy_ad", inst_addr, 32'h68);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_read", 32'(inst_read), 32'd0);
    chk("t5_rst_valid", 32'(if_valid), 32'd0);
    chk("t5_rst_pc", if_pc, 32'h0);
    tick();
    chk("t5_refetch", inst_addr, 32'h60);
    chk("t5_ref_read", 32'(inst_read), 32'd1);

`ifdef IFQ_PERF_EN
    // 6: 3 pushes, 1 redirect, 2 stalled cycles
    do_reset(0, 1'b1);
    chk("t6_rst_fetch", perf_fetch_cnt, 32'd0);
    chk("t6_rst_flush", perf_flush_cnt, 32'd0);
    chk("t6_rst_stall", perf_stall_cnt, 32'd0);
    tick();
    tick();
    dec_ready = 1'b0;
    tick();
    tick();
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("t6_fetch", perf_fetch_cnt, 32'd3);
    chk("t6_flush", perf_flush_cnt, 32'd1);
    chk("t6_stall", perf_stall_cnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
